// File: rtl/regfile_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_pkg : shared width helpers and popcount for regfile_z_nr1w_sb  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package regfile_pkg;

   // Widest busy vector popcount accepts; callers zero-extend into it.
   localparam int MAX_NREGS = 1024;

   function automatic int addr_width(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

   function automatic int count_width(input int nregs);
      return $clog2(nregs + 1);
   endfunction

   function automatic int popcount(input logic [MAX_NREGS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_NREGS; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_scoreboard : busy-bit array with set-over-clear and count      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = 32,
   localparam int AW = addr_width(NREGS),
   localparam int CW = count_width(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_en_i,
   input  logic [AW-1:0]    clr_addr_i,
   input  logic             set_en_i,
   input  logic [AW-1:0]    set_addr_i,
   output logic [NREGS-1:0] busy_o,
   output logic [CW-1:0]    busy_count_o
);

   logic [NREGS-1:0]     busy_q, busy_d;
   logic [CW-1:0]        count_q, count_d;
   logic [MAX_NREGS-1:0] busy_ext;

   // Set is applied after clear so a new producer issued behind a retiring one wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i && (clr_addr_i != '0)) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      busy_ext = '0;
      busy_ext[NREGS-1:0] = busy_d;
      count_d = CW'(popcount(busy_ext));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_o       = busy_q;
   assign busy_count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/regfile_z_nr1w_sb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_z_nr1w_sb : zero-entry register file, NRD reads, 1 write,      |
// |                     busy-bit scoreboard and optional write bypass      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module regfile_z_nr1w_sb
   import regfile_pkg::*;
#(
   parameter int NREGS  = 32,
   parameter int W      = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 0,
   localparam int AW = addr_width(NREGS),
   localparam int CW = count_width(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [W-1:0]      wdata_i,
   input  logic [NRD*AW-1:0] raddr_i,
   output logic [NRD*W-1:0]  rdata_o,
   output logic [NRD-1:0]    rbusy_o,
   input  logic              sb_set_i,
   input  logic [AW-1:0]     sb_addr_i,
   output logic [CW-1:0]     busy_count_o
);

   logic [W-1:0]     mem_q [1:NREGS-1];
   logic [NREGS-1:0] busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 1; e < NREGS; e++) mem_q[e] <= '0;
      end else if (wen_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   regfile_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_en_i     (wen_i),
      .clr_addr_i   (waddr_i),
      .set_en_i     (sb_set_i),
      .set_addr_i   (sb_addr_i),
      .busy_o       (busy),
      .busy_count_o (busy_count_o)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;
      assign ra  = raddr_i[i*AW +: AW];
      // Bypass is suppressed in reset so outputs read zero while rst_n is low.
      assign hit = (BYPASS != 0) && rst_n && wen_i && (waddr_i == ra) && (ra != '0);
      assign rdata_o[i*W +: W] = (ra == '0) ? '0 : (hit ? wdata_i : mem_q[ra]);
      assign rbusy_o[i]        = busy[ra] & ~hit;
   end

endmodule
`default_nettype wire
